// File: rtl/muldiv_pkg.sv
//==============================================================================
// Module      : muldiv_pkg
// Description : Shared state encoding and op constants for the MULT/DIV
//               sequencer; the main control unit imports the op constants.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package muldiv_pkg;

    localparam int ITER_CNT = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2,
        FIX     = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/muldiv_ctrl_div_step.sv
//==============================================================================
// Module      : div_step
// Description : One combinational restoring-divide step on {R,Q}.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0]   shifted_rem;
    logic [WIDTH+1:0] trial;

    // Two guard bits keep the borrow unambiguous even if R has its top bit set.
    always_comb begin
        shifted_rem = {rem_in, quo_in[WIDTH-1]};
        trial       = {1'b0, shifted_rem} - {2'b00, divisor};
        if (trial[WIDTH+1]) begin
            rem_out = shifted_rem[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b0};
        end else begin
            rem_out = trial[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b1};
        end
    end

endmodule

`default_nettype wire

// File: rtl/muldiv_ctrl.sv
//==============================================================================
// Module      : muldiv_ctrl
// Description : Iterative signed MULT/DIV sequencer owning HI/LO (33 cycles).
//               Optional macro MULDIV_DIV_ZERO_EXC_EN: divide-by-zero trap.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = ITER_CNT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int               CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic               op_reg;
    logic               neg_main;
    logic               neg_rem;
    logic [WIDTH-1:0]   operand;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   div_rem;
    logic [WIDTH-1:0]   div_quo;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_fixed;
    logic [WIDTH-1:0]   rem_fixed;

    // The most negative value maps onto itself, read back as unsigned 2^(W-1).
    assign a_mag = a_in[WIDTH-1] ? (~a_in + 1'b1) : a_in;
    assign b_mag = b_in[WIDTH-1] ? (~b_in + 1'b1) : b_in;

    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in  (acc_hi),
        .quo_in  (acc_lo),
        .divisor (operand),
        .rem_out (div_rem),
        .quo_out (div_quo)
    );

    assign prod_fixed = neg_main ? (~{acc_hi, acc_lo} + 1'b1) : {acc_hi, acc_lo};
    assign quo_fixed  = neg_main ? (~acc_lo + 1'b1) : acc_lo;
    assign rem_fixed  = neg_rem  ? (~acc_hi + 1'b1) : acc_hi;

`ifndef MULDIV_DIV_ZERO_EXC_EN
    assign div_zero = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= '0;
            op_reg   <= OP_MULT;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            operand  <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
`ifdef MULDIV_DIV_ZERO_EXC_EN
            div_zero <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef MULDIV_DIV_ZERO_EXC_EN
            div_zero <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
`ifdef MULDIV_DIV_ZERO_EXC_EN
                        if (op == OP_DIV && b_in == '0) begin
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                        end else
`endif
                        begin
                            op_reg  <= op;
                            count   <= '0;
                            busy    <= 1'b1;
                            acc_hi  <= '0;
                            // A zero divisor leaves Q all-ones, which must not be negated.
                            neg_main <= (a_in[WIDTH-1] ^ b_in[WIDTH-1]) &
                                        ((op == OP_MULT) || (b_in != '0));
                            neg_rem  <= a_in[WIDTH-1];
                            if (op == OP_MULT) begin
                                operand <= a_mag;
                                acc_lo  <= b_mag;
                                state   <= MUL_RUN;
                            end else begin
                                operand <= b_mag;
                                acc_lo  <= a_mag;
                                state   <= DIV_RUN;
                            end
                        end
                    end
                end
                MUL_RUN: begin
                    acc_hi <= mul_sum[WIDTH:1];
                    acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    count  <= count + 1'b1;
                    if (count == LAST) state <= FIX;
                end
                DIV_RUN: begin
                    acc_hi <= div_rem;
                    acc_lo <= div_quo;
                    count  <= count + 1'b1;
                    if (count == LAST) state <= FIX;
                end
                FIX: begin
                    if (op_reg == OP_MULT) begin
                        {hi_out, lo_out} <= prod_fixed;
                    end else begin
                        hi_out <= rem_fixed;
                        lo_out <= quo_fixed;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
